banco_reg_sb: RTL and testbench
===============================

# banco_reg_sb

Parametrised register file for the pipelined core, succeeding the single-write, two-read bank. It adds a configurable number of read ports, a second write port for the load/writeback pipe, and write-to-read bypass. It also carries a built-in scoreboard: one pending bit per register, from which it raises a stall to the hazard unit. It sits in the decode stage; writeback writes arrive from WB, and issue reservations arrive from decode.

## Interface
- DATA_W, 32: register width
- NREGS, 32: register count, power of two; ADDR_W = $clog2(NREGS)
- NRD, 2: read ports, 1..4
- SP_IDX, 2: stack pointer index; SP_INIT = STACK_ADDRESS
- GP_IDX, 3: global pointer index; GP_INIT = GLOBAL_POINTER
- iCLK  in  1  clock, all state updates on rising edge
- iRST  in  1  reset, asynchronous, active-high
- iRdAddr  in  NRD*ADDR_W  read addresses, port k in bits [k*ADDR_W +: ADDR_W]
- oRdData  out  NRD*DATA_W  read data, combinational
- oRdPending  out  NRD  port k targets a pending register
- iWrEn0 / iWrAddr0 / iWrData0  in  1 / ADDR_W / DATA_W  write port 0 (ALU writeback)
- iWrEn1 / iWrAddr1 / iWrData1  in  1 / ADDR_W / DATA_W  write port 1 (load writeback)
- iIssueEn / iIssueDst  in  1 / ADDR_W  reserve destination register
- iRdUse  in  NRD  port k operand is actually consumed this cycle
- iFlush  in  1  clear all pending bits
- oStall  out  1  hazard stall request
- iRegDispSelect / oRegDisp  in ADDR_W / out DATA_W  debug display port, combinational, no bypass

## Operation
- Register 0 reads 0 always. Writes to 0 are discarded. It never becomes pending, and issue to 0 is ignored.
- Writes: when both ports are enabled to the same non-zero address, port 1 wins. Distinct addresses are both written.
- Read port k: if any enabled write targets iRdAddr[k] (non-zero) this cycle, return that write data (port 1 priority). Otherwise return the array value.
- Scoreboard: pending[r] is set at the edge with iIssueEn and iIssueDst=r. It is cleared at the edge where any enabled write targets r.
- Simultaneous set and clear on the same r: set wins, because a new producer overrides the old one.
- iFlush: all pending bits clear at the edge. A same-cycle issue is still applied (flush first, then set).
- oRdPending[k] = pending[iRdAddr[k]] && !(bypass hit on port k).
- oStall = OR over k of (iRdUse[k] && oRdPending[k]). It is combinational and unregistered.
- Stall does not block writes or issue. Decode must drop iIssueEn while oStall is high.

## Timing
- Read and bypass paths are combinational, with zero-cycle latency.
- Write becomes visible in the array after the rising edge. Within the same cycle it is visible via the bypass.
- Pending bit is visible on oRdPending the cycle after issue. A register written in cycle t is not pending in t (bypass) nor after t.
- Reset, asynchronous: every register is 0, except SP_IDX = SP_INIT and GP_IDX = GP_INIT. All pending bits are 0.
- Outputs during reset: oStall = 0, oRdPending = 0, oRdData = reset contents. Reset during a stall drops it immediately.
- After iRST deasserts, the first edge behaves normally. There are no extra idle cycles.

## Structure
- Shared package reg_pkg: STACK_ADDRESS, GLOBAL_POINTER, and the default SP/GP indices. The same constants are used by the linker and ROM init.
- Sub-module reg_scoreboard holds the pending vector, set/clear/flush logic and per-port lookup. It is parametrised by NREGS and NRD.
- Top-level banco_reg_sb contains the array, write priority, bypass muxes and the oStall OR.

## Test plan
- Reset, then read with iRdAddr={3,2} -> oRdData = {GLOBAL_POINTER, STACK_ADDRESS}, oStall = 0. Write 0x55 to r0 -> r0 still reads 0.
- Both ports write r5 in the same cycle (0x11 on port 0, 0x22 on port 1) -> same-cycle read of r5 = 0x22, and after the edge the array holds 0x22. Distinct addresses r6/r7 -> both updated.
- Issue r8, next cycle read r8 with iRdUse=1 -> oStall = 1. Write r8 = 0xABCD that cycle -> oStall = 0, data = 0xABCD via bypass, pending cleared after the edge.
- Issue r9 and write r9 in the same cycle -> r9 pending next cycle. Reading r9 with iRdUse=0 -> oStall = 0 but oRdPending = 1.
- Issue r10, r11, then iFlush together with issue r12 -> only r12 pending. Assert iRST mid-stall -> oStall drops asynchronously, SP/GP restored.
- NRD=4 build: four ports read four distinct pending/non-pending registers -> per-port oRdPending is correct, and oRegDisp matches the array without bypass.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared constants for the register file. The linker and the ROM init use the
// same stack and global pointer values, so they are defined in one place.
package reg_pkg;

   localparam int unsigned XLEN = 32;

   // Initial stack pointer (top of data RAM, word aligned)
   localparam logic [XLEN-1:0] STACK_ADDRESS  = 32'h0000_3FFC;
   // Initial global pointer (middle of the small-data area)
   localparam logic [XLEN-1:0] GLOBAL_POINTER = 32'h0000_1800;

   // Default architectural indices of sp and gp
   localparam int SP_IDX_DEF = 2;
   localparam int GP_IDX_DEF = 3;

endpackage : reg_pkg

// File: rtl/reg_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by issue reservations,
// cleared by writeback, bulk-cleared by flush. Also looks up the pending state
// of every read port, masked when that port is served by the write bypass.
module reg_scoreboard #(
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int ADDR_W = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en0,
   input  logic [ADDR_W-1:0]     wr_addr0,
   input  logic                  wr_en1,
   input  logic [ADDR_W-1:0]     wr_addr1,
   input  logic                  issue_en,
   input  logic [ADDR_W-1:0]     issue_dst,
   input  logic                  flush,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   input  logic [NRD-1:0]        rd_hit,
   output logic [NRD-1:0]        rd_pending
);

   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_nxt;

   // Next pending vector: flush, then writeback clears, then the issue set
   // (a new producer overrides the write that retires the old one)
   always_comb begin
      pending_nxt = pending;
      if (flush)
         pending_nxt = '0;
      if (wr_en0 && (wr_addr0 != '0))
         pending_nxt[wr_addr0] = 1'b0;
      if (wr_en1 && (wr_addr1 != '0))
         pending_nxt[wr_addr1] = 1'b0;
      if (issue_en && (issue_dst != '0))
         pending_nxt[issue_dst] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Pending state register, cleared asynchronously by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

   // Per-port lookup; a bypassed operand is already available, and nothing is
   // reported pending while reset is held
   always_comb begin
      rd_pending = '0;
      for (int k = 0; k < NRD; k++) begin
         rd_pending[k] = !rst && pending[rd_addr[k*ADDR_W +: ADDR_W]] && !rd_hit[k];
      end
   end

endmodule : reg_scoreboard

// File: rtl/banco_reg_sb.sv
// Register file for the pipelined core: NRD combinational read ports with
// write-to-read bypass, two write ports (port 1 wins on collision), a debug
// display port without bypass, and a pending-bit scoreboard driving oStall.
module banco_reg_sb
   import reg_pkg::*;
#(
   parameter int                DATA_W = 32,
   parameter int                NREGS  = 32,
   parameter int                NRD    = 2,
   parameter int                SP_IDX = SP_IDX_DEF,
   parameter int                GP_IDX = GP_IDX_DEF,
   parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(STACK_ADDRESS),
   parameter logic [DATA_W-1:0] GP_INIT = DATA_W'(GLOBAL_POINTER),
   parameter int                ADDR_W = $clog2(NREGS)
) (
   input  logic                  iCLK,
   input  logic                  iRST,
   input  logic [NRD*ADDR_W-1:0] iRdAddr,
   output logic [NRD*DATA_W-1:0] oRdData,
   output logic [NRD-1:0]        oRdPending,
   input  logic                  iWrEn0,
   input  logic [ADDR_W-1:0]     iWrAddr0,
   input  logic [DATA_W-1:0]     iWrData0,
   input  logic                  iWrEn1,
   input  logic [ADDR_W-1:0]     iWrAddr1,
   input  logic [DATA_W-1:0]     iWrData1,
   input  logic                  iIssueEn,
   input  logic [ADDR_W-1:0]     iIssueDst,
   input  logic [NRD-1:0]        iRdUse,
   input  logic                  iFlush,
   output logic                  oStall,
   input  logic [ADDR_W-1:0]     iRegDispSelect,
   output logic [DATA_W-1:0]     oRegDisp
);

   logic [DATA_W-1:0] regs [NREGS];
   logic [NRD-1:0]    rd_hit;

   function automatic logic [DATA_W-1:0] reset_value(input int r);
      if (r == SP_IDX)
         return SP_INIT;
      else if (r == GP_IDX)
         return GP_INIT;
      else
         return '0;
   endfunction

   // Register array: reset to the boot image, port 1 written last so it wins
   // when both ports target the same register; r0 is never written
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         for (int r = 0; r < NREGS; r++)
            regs[r] <= reset_value(r);
      end else begin
         if (iWrEn0 && (iWrAddr0 != '0))
            regs[iWrAddr0] <= iWrData0;
         if (iWrEn1 && (iWrAddr1 != '0))
            regs[iWrAddr1] <= iWrData1;
      end
   end

   // Read ports with same-cycle bypass; bypass is suppressed during reset so
   // the ports show the reset contents
   always_comb begin
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              hit0;
      logic              hit1;
      oRdData = '0;
      rd_hit  = '0;
      addr    = '0;
      data    = '0;
      hit0    = 1'b0;
      hit1    = 1'b0;
      for (int k = 0; k < NRD; k++) begin
         addr = iRdAddr[k*ADDR_W +: ADDR_W];
         hit0 = !iRST && iWrEn0 && (iWrAddr0 == addr) && (addr != '0);
         hit1 = !iRST && iWrEn1 && (iWrAddr1 == addr) && (addr != '0);
         data = regs[addr];
         if (hit0)
            data = iWrData0;
         if (hit1)
            data = iWrData1;
         rd_hit[k] = hit0 | hit1;
         oRdData[k*DATA_W +: DATA_W] = data;
      end
   end

   // Debug display reads the array directly
   always_comb begin
      oRegDisp = regs[iRegDispSelect];
   end

   reg_scoreboard #(
      .NREGS  (NREGS),
      .NRD    (NRD),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk        (iCLK),
      .rst        (iRST),
      .wr_en0     (iWrEn0),
      .wr_addr0   (iWrAddr0),
      .wr_en1     (iWrEn1),
      .wr_addr1   (iWrAddr1),
      .issue_en   (iIssueEn),
      .issue_dst  (iIssueDst),
      .flush      (iFlush),
      .rd_addr    (iRdAddr),
      .rd_hit     (rd_hit),
      .rd_pending (oRdPending)
   );

   // Stall when any consumed operand is still waiting for its producer
   always_comb begin
      oStall = |(iRdUse & oRdPending);
   end

endmodule : banco_reg_sb

// File: tb/tb_banco_reg_sb.sv
// Bench for banco_reg_sb (four read-port build): a table of per-cycle vectors
// plus hand-written sequences for display, reset-during-stall and restart.
module tb_banco_reg_sb;
   import reg_pkg::*;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int NRD = 4;

   logic                iCLK = 1'b0;
   logic                iRST;
   logic [NRD*AW-1:0]   iRdAddr;
   logic [NRD*DW-1:0]   oRdData;
   logic [NRD-1:0]      oRdPending;
   logic                iWrEn0, iWrEn1;
   logic [AW-1:0]       iWrAddr0, iWrAddr1;
   logic [DW-1:0]       iWrData0, iWrData1;
   logic                iIssueEn;
   logic [AW-1:0]       iIssueDst;
   logic [NRD-1:0]      iRdUse;
   logic                iFlush;
   logic                oStall;
   logic [AW-1:0]       iRegDispSelect;
   logic [DW-1:0]       oRegDisp;

   banco_reg_sb #(.DATA_W(DW), .NREGS(32), .NRD(NRD)) dut (
      .iCLK(iCLK), .iRST(iRST), .iRdAddr(iRdAddr), .oRdData(oRdData),
      .oRdPending(oRdPending), .iWrEn0(iWrEn0), .iWrAddr0(iWrAddr0),
      .iWrData0(iWrData0), .iWrEn1(iWrEn1), .iWrAddr1(iWrAddr1),
      .iWrData1(iWrData1), .iIssueEn(iIssueEn), .iIssueDst(iIssueDst),
      .iRdUse(iRdUse), .iFlush(iFlush), .oStall(oStall),
      .iRegDispSelect(iRegDispSelect), .oRegDisp(oRegDisp)
   );

   always #5 iCLK = ~iCLK;

   typedef struct packed {
      logic [NRD-1:0][DW-1:0] d;
      logic [NRD-1:0]         p;
      logic                   s;
   } exp_t;

   typedef struct {
      logic             w0e;
      logic [AW-1:0]    w0a;
      logic [DW-1:0]    w0d;
      logic             w1e;
      logic [AW-1:0]    w1a;
      logic [DW-1:0]    w1d;
      logic             ie;
      logic [AW-1:0]    id;
      logic             fl;
      logic [NRD-1:0][AW-1:0] ra;
      logic [NRD-1:0]   use_k;
      exp_t             e;
   } vec_t;

   function automatic vec_t mk(
      input logic w0e, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
      input logic w1e, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
      input logic ie, input logic [AW-1:0] id, input logic fl,
      input logic [NRD-1:0][AW-1:0] ra, input logic [NRD-1:0] use_k,
      input logic [NRD-1:0][DW-1:0] ed, input logic [NRD-1:0] ep, input logic es);
      vec_t v;
      v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
      v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
      v.ie = ie; v.id = id; v.fl = fl; v.ra = ra; v.use_k = use_k;
      v.e.d = ed; v.e.p = ep; v.e.s = es;
      return v;
   endfunction

   vec_t vecs [15];
   exp_t exp_q [$];
   int   n_total = 0;
   int   n_pass  = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
      n_total++;
      if (act === exp_v)
         n_pass++;
      else
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
   endtask

   task automatic idle_inputs();
      iWrEn0 = 0; iWrAddr0 = '0; iWrData0 = '0;
      iWrEn1 = 0; iWrAddr1 = '0; iWrData1 = '0;
      iIssueEn = 0; iIssueDst = '0; iFlush = 0; iRdUse = '0;
      iRdAddr = '0; iRegDispSelect = '0;
   endtask

   task automatic check_ports(input string tag, input exp_t e);
      for (int k = 0; k < NRD; k++)
         check($sformatf("%s data[%0d]", tag, k), oRdData[k*DW +: DW], e.d[k]);
      check({tag, " pending"}, DW'(oRdPending), DW'(e.p));
      check({tag, " stall"}, DW'(oStall), DW'(e.s));
   endtask

   initial begin
      exp_t e;
      // Vector table: inputs for one cycle, outputs expected before its edge
      //            w0e w0a  w0d        w1e w1a  w1d       ie id  fl  ra{p3,p2,p1,p0}  use      data{p3,p2,p1,p0}                                   pend     stall
      vecs[0]  = mk(1, 5'd0, 32'h55,    0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd3,5'd2},    4'b0000, {32'h0,32'h0,GLOBAL_POINTER,STACK_ADDRESS}, 4'b0000, 0);
      vecs[1]  = mk(1, 5'd5, 32'h11,    1, 5'd5, 32'h22,  0, 5'd0, 0, {5'd5,5'd0,5'd0,5'd0},    4'b0000, {32'h22,32'h0,32'h0,32'h0},       4'b0000, 0);
      vecs[2]  = mk(1, 5'd6, 32'h66,    1, 5'd7, 32'h77,  0, 5'd0, 0, {5'd7,5'd6,5'd5,5'd0},    4'b0000, {32'h77,32'h66,32'h22,32'h0},     4'b0000, 0);
      vecs[3]  = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   1, 5'd8, 0, {5'd7,5'd6,5'd0,5'd0},    4'b0000, {32'h77,32'h66,32'h0,32'h0},      4'b0000, 0);
      vecs[4]  = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd0,5'd8},    4'b0001, {32'h0,32'h0,32'h0,32'h0},        4'b0001, 1);
      vecs[5]  = mk(1, 5'd8, 32'hABCD,  0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd0,5'd8},    4'b0001, {32'h0,32'h0,32'h0,32'hABCD},     4'b0000, 0);
      vecs[6]  = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd0,5'd8},    4'b0001, {32'h0,32'h0,32'h0,32'hABCD},     4'b0000, 0);
      vecs[7]  = mk(0, 5'd0, 32'h0,     1, 5'd9, 32'h99,  1, 5'd9, 0, {5'd0,5'd0,5'd0,5'd9},    4'b0000, {32'h0,32'h0,32'h0,32'h99},       4'b0000, 0);
      vecs[8]  = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd0,5'd9},    4'b0000, {32'h0,32'h0,32'h0,32'h99},       4'b0001, 0);
      vecs[9]  = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   1, 5'd10,0, {5'd9,5'd0,5'd0,5'd0},    4'b1000, {32'h99,32'h0,32'h0,32'h0},       4'b1000, 1);
      vecs[10] = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   1, 5'd11,0, {5'd10,5'd9,5'd0,5'd0},   4'b0000, {32'h0,32'h99,32'h0,32'h0},       4'b1100, 0);
      vecs[11] = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   1, 5'd12,1, {5'd12,5'd11,5'd10,5'd9}, 4'b0000, {32'h0,32'h0,32'h0,32'h99},       4'b0111, 0);
      vecs[12] = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd12,5'd11,5'd10,5'd9}, 4'b1111, {32'h0,32'h0,32'h0,32'h99},       4'b1000, 1);
      vecs[13] = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   1, 5'd0, 0, {5'd12,5'd7,5'd5,5'd9},   4'b0000, {32'h0,32'h77,32'h22,32'h99},     4'b1000, 0);
      vecs[14] = mk(0, 5'd0, 32'h0,     0, 5'd0, 32'h0,   0, 5'd0, 0, {5'd0,5'd0,5'd0,5'd0},    4'b1111, {32'h0,32'h0,32'h0,32'h0},        4'b0000, 0);

      // Reset state, with a write to r5 attempted during reset
      idle_inputs();
      iRST = 1'b1;
      iRdAddr = {5'd5, 5'd0, 5'd3, 5'd2};
      iWrEn0 = 1; iWrAddr0 = 5'd5; iWrData0 = 32'hBAD;
      iRdUse = 4'b1111;
      #3;
      e.d = {32'h0, 32'h0, GLOBAL_POINTER, STACK_ADDRESS}; e.p = '0; e.s = 1'b0;
      check_ports("reset", e);
      #9;
      idle_inputs();
      iRST = 1'b0;

      // Table: drive after the edge, expected pushed with the drive,
      // popped and compared on the falling edge
      for (int i = 0; i < 15; i++) begin
         @(posedge iCLK); #1;
         iWrEn0 = vecs[i].w0e; iWrAddr0 = vecs[i].w0a; iWrData0 = vecs[i].w0d;
         iWrEn1 = vecs[i].w1e; iWrAddr1 = vecs[i].w1a; iWrData1 = vecs[i].w1d;
         iIssueEn = vecs[i].ie; iIssueDst = vecs[i].id; iFlush = vecs[i].fl;
         iRdAddr = vecs[i].ra; iRdUse = vecs[i].use_k;
         exp_q.push_back(vecs[i].e);
         @(negedge iCLK);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL vec%0d: scoreboard empty, got 0 entries, expected 1", i);
         end else begin
            e = exp_q.pop_front();
            check_ports($sformatf("vec%0d", i), e);
         end
      end

      // Display port shows the array, not the in-flight write
      @(posedge iCLK); #1;
      idle_inputs();
      iWrEn0 = 1; iWrAddr0 = 5'd7; iWrData0 = 32'hDEAD;
      iRdAddr = {5'd0, 5'd0, 5'd0, 5'd7};
      iRegDispSelect = 5'd7;
      @(negedge iCLK);
      check("disp bypass data", oRdData[0 +: DW], 32'hDEAD);
      check("disp no bypass", oRegDisp, 32'h77);
      @(posedge iCLK); #1;
      iWrEn0 = 0;
      @(negedge iCLK);
      check("disp after write", oRegDisp, 32'hDEAD);

      // Reset during a stall on pending r12
      iRdAddr = {5'd5, 5'd3, 5'd2, 5'd12};
      iRdUse  = 4'b0001;
      #1;
      check("stall before reset", DW'(oStall), 32'h1);
      iRST = 1'b1;
      #1;
      check("stall in reset", DW'(oStall), 32'h0);
      check("pending in reset", DW'(oRdPending), 32'h0);
      check("sp restored", oRdData[1*DW +: DW], STACK_ADDRESS);
      check("gp restored", oRdData[2*DW +: DW], GLOBAL_POINTER);
      check("r5 cleared", oRdData[3*DW +: DW], 32'h0);
      @(negedge iCLK); #1;
      iRST = 1'b0;

      // First edge after reset release behaves normally
      @(posedge iCLK); #1;
      iWrEn1 = 1; iWrAddr1 = 5'd13; iWrData1 = 32'h1313;
      iRdAddr = {5'd0, 5'd0, 5'd13, 5'd12};
      iRdUse  = 4'b0011;
      @(negedge iCLK);
      check("post-reset stall", DW'(oStall), 32'h0);
      check("post-reset bypass", oRdData[1*DW +: DW], 32'h1313);
      @(posedge iCLK); #1;
      iWrEn1 = 0;
      @(negedge iCLK);
      check("post-reset array", oRdData[1*DW +: DW], 32'h1313);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_banco_reg_sb
